// File: rtl/axi4_duth_noc_pkg.sv
// axi4_duth_noc_pkg: shared flit-format constants and NI injector state type.
package axi4_duth_noc_pkg;
  localparam int FLIT_HEAD_BIT = 1;
  localparam int FLIT_TAIL_BIT = 0;
  typedef enum logic {NI_INJ_IDLE, NI_INJ_BODY} ni_inj_state_type;
endpackage

// File: rtl/ni_flit_injector_if.sv
// ni_flit_injector_if: descriptor, payload and router-channel signals of the flit injector.
interface ni_flit_injector_if #(
  parameter int FLIT_WIDTH     = 16,
  parameter int DST_ADDR_WIDTH = 2,
  parameter int LEN_WIDTH      = 4
);
  logic                      pkt_valid;
  logic                      pkt_ready;
  logic [DST_ADDR_WIDTH-1:0] pkt_dst;
  logic [LEN_WIDTH-1:0]      pkt_len;
  logic                      pld_valid;
  logic                      pld_ready;
  logic [FLIT_WIDTH-3:0]     pld_data;
  logic [FLIT_WIDTH-1:0]     data_out;
  logic                      valid_out;
  logic                      front_notify;
  modport master (
    output pkt_valid, pkt_dst, pkt_len, pld_valid, pld_data, front_notify,
    input  pkt_ready, pld_ready, data_out, valid_out
  );
  modport slave (
    input  pkt_valid, pkt_dst, pkt_len, pld_valid, pld_data, front_notify,
    output pkt_ready, pld_ready, data_out, valid_out
  );
endinterface

// File: rtl/ni_credit_counter.sv
// ni_credit_counter: mirrors free slots in the router input buffer.
module ni_credit_counter #(
  parameter  int MAX_CREDITS = 3,
  localparam int CW          = $clog2(MAX_CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          consume,
  input  logic          credit_in,
  output logic          has_credit,
  output logic [CW-1:0] credits
);
  localparam logic [CW-1:0] MAX = CW'(MAX_CREDITS);
  logic [CW-1:0] credits_q, credits_d;
  // a return at full count is a router protocol error; the counter saturates
  always_comb
    credits_d = (consume && !credit_in) ? credits_q - CW'(1) :
                (credit_in && !consume && credits_q != MAX) ? credits_q + CW'(1) : credits_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) credits_q <= MAX;
    else      credits_q <= credits_d;
  always_ff @(posedge clk)
    if (rst) begin
      assert (!(consume && credits_q == '0))
        else $error("credit underflow: flit sent with no credit");
      assert (!(credit_in && !consume && credits_q == MAX))
        else $warning("credit overflow: front_notify with counter at MAX_CREDITS");
    end
  assign has_credit = credits_q != '0;
  assign credits    = credits_q;
endmodule

// File: rtl/ni_flit_injector.sv
// ni_flit_injector: serializes descriptor + payload words into head/body/tail flits
// on a credit-based router input channel.
module ni_flit_injector
  import axi4_duth_noc_pkg::*;
#(
  parameter int FLIT_WIDTH     = 16,
  parameter int DST_PNT        = 4,
  parameter int DST_ADDR_WIDTH = 2,
  parameter int MAX_CREDITS    = 3,
  parameter int LEN_WIDTH      = 4
) (
  input logic               clk,
  input logic               rst,
  ni_flit_injector_if.slave bus
);
  localparam int CW = $clog2(MAX_CREDITS + 1);
  ni_inj_state_type      state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [FLIT_WIDTH-1:0] data_q, data_d, head, body;
  logic                  valid_q, has_credit, send;
  logic [CW-1:0]         credits_unused;
  always_comb begin
    head = '0;
    head[DST_PNT +: DST_ADDR_WIDTH] = bus.pkt_dst;
    head[FLIT_HEAD_BIT] = 1'b1;
    head[FLIT_TAIL_BIT] = bus.pkt_len == '0;
    body = {bus.pld_data, 2'b00};
    body[FLIT_TAIL_BIT] = rem_q == LEN_WIDTH'(1);
    bus.pkt_ready = rst && state_q == NI_INJ_IDLE && bus.pkt_valid && has_credit;
    bus.pld_ready = rst && state_q == NI_INJ_BODY && bus.pld_valid && has_credit;
    send = bus.pkt_ready || bus.pld_ready;
    state_d = bus.pkt_ready ? (bus.pkt_len == '0 ? NI_INJ_IDLE : NI_INJ_BODY) :
              (bus.pld_ready && rem_q == LEN_WIDTH'(1)) ? NI_INJ_IDLE : state_q;
    rem_d  = bus.pkt_ready ? bus.pkt_len : bus.pld_ready ? rem_q - LEN_WIDTH'(1) : rem_q;
    data_d = bus.pkt_ready ? head : bus.pld_ready ? body : data_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= NI_INJ_IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= send;
    end
  ni_credit_counter #(.MAX_CREDITS(MAX_CREDITS)) u_cred (
    .clk       (clk),
    .rst       (rst),
    .consume   (send),
    .credit_in (bus.front_notify),
    .has_credit(has_credit),
    .credits   (credits_unused)
  );
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_ni_flit_injector.sv
// tb_ni_flit_injector: table-driven and directed checks of the flit injector.
module tb_ni_flit_injector;
  import axi4_duth_noc_pkg::*;
  typedef struct {
    logic        pv;
    logic [1:0]  dst;
    logic [3:0]  len;
    logic        dv;
    logic [13:0] pd;
    logic        fn;
    logic        e_pr;
    logic        e_dr;
    logic        e_vo;
    logic [15:0] e_do;
    logic [1:0]  e_cr;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int cnt;
  vec_t tbl[10];
  ni_flit_injector_if #(.FLIT_WIDTH(16), .DST_ADDR_WIDTH(2), .LEN_WIDTH(4)) bus ();
  ni_flit_injector #(.FLIT_WIDTH(16), .DST_PNT(4), .DST_ADDR_WIDTH(2), .MAX_CREDITS(3), .LEN_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic pv, logic [1:0] dst, logic [3:0] len, logic dv, logic [13:0] pd,
                              logic fn, logic e_pr, logic e_dr, logic e_vo, logic [15:0] e_do, logic [1:0] e_cr);
    vec_t v;
    v.pv = pv; v.dst = dst; v.len = len; v.dv = dv; v.pd = pd; v.fn = fn;
    v.e_pr = e_pr; v.e_dr = e_dr; v.e_vo = e_vo; v.e_do = e_do; v.e_cr = e_cr;
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic cyc(logic pv, logic [1:0] dst, logic [3:0] len, logic dv, logic [13:0] pd, logic fn);
    @(negedge clk);
    bus.pkt_valid = pv; bus.pkt_dst = dst; bus.pkt_len = len;
    bus.pld_valid = dv; bus.pld_data = pd; bus.front_notify = fn;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.pkt_valid = 0; bus.pld_valid = 0; bus.front_notify = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    tbl[0] = mk(1, 2, 3, 0, 14'h000, 0, 1, 0, 0, 16'h0000, 3);
    tbl[1] = mk(0, 0, 0, 1, 14'h1AB, 0, 0, 1, 1, 16'h0022, 2);
    tbl[2] = mk(0, 0, 0, 1, 14'h2CD, 1, 0, 1, 1, 16'h06AC, 1);
    tbl[3] = mk(0, 0, 0, 1, 14'h3EF, 1, 0, 1, 1, 16'h0B34, 1);
    tbl[4] = mk(0, 0, 0, 0, 14'h000, 1, 0, 0, 1, 16'h0FBD, 1);
    tbl[5] = mk(0, 0, 0, 0, 14'h000, 1, 0, 0, 0, 16'h0000, 2);
    tbl[6] = mk(1, 3, 0, 0, 14'h000, 0, 1, 0, 0, 16'h0000, 3);
    tbl[7] = mk(1, 1, 0, 0, 14'h000, 0, 1, 0, 1, 16'h0033, 2);
    tbl[8] = mk(0, 0, 0, 0, 14'h000, 1, 0, 0, 1, 16'h0013, 1);
    tbl[9] = mk(0, 0, 0, 0, 14'h000, 1, 0, 0, 0, 16'h0000, 2);
    bus.pkt_valid = 1; bus.pkt_dst = 3; bus.pkt_len = 0;
    bus.pld_valid = 1; bus.pld_data = 14'h3FF; bus.front_notify = 0;
    #12;
    chk("rst_pkt_ready", 32'(bus.pkt_ready), 0);
    chk("rst_pld_ready", 32'(bus.pld_ready), 0);
    chk("rst_valid_out", 32'(bus.valid_out), 0);
    chk("rst_data_out", 32'(bus.data_out), 0);
    chk("rst_credits", 32'(dut.u_cred.credits_q), 3);
    chk("rst_state", 32'(dut.state_q == NI_INJ_IDLE), 1);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].pv, tbl[i].dst, tbl[i].len, tbl[i].dv, tbl[i].pd, tbl[i].fn);
      chk($sformatf("tbl%0d_pkt_ready", i), 32'(bus.pkt_ready), 32'(tbl[i].e_pr));
      chk($sformatf("tbl%0d_pld_ready", i), 32'(bus.pld_ready), 32'(tbl[i].e_dr));
      chk($sformatf("tbl%0d_valid_out", i), 32'(bus.valid_out), 32'(tbl[i].e_vo));
      chk($sformatf("tbl%0d_credits", i), 32'(dut.u_cred.credits_q), 32'(tbl[i].e_cr));
      if (tbl[i].e_vo) chk($sformatf("tbl%0d_data_out", i), 32'(bus.data_out), 32'(tbl[i].e_do));
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("tbl_end_credits", 32'(dut.u_cred.credits_q), 3);
    chk("tbl_end_state", 32'(dut.state_q == NI_INJ_IDLE), 1);
    // credit exhaustion: head + 2 bodies, then stall until one credit returns
    do_reset();
    cyc(1, 0, 5, 1, 14'h155, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1, 14'h155, 0);
      cnt += int'(bus.valid_out);
    end
    chk("stall_flit_count", 32'(cnt), 3);
    chk("stall_pld_ready", 32'(bus.pld_ready), 0);
    chk("stall_valid_out", 32'(bus.valid_out), 0);
    cyc(0, 0, 0, 1, 14'h155, 1);
    chk("notify_cycle_pld_ready", 32'(bus.pld_ready), 0);
    cyc(0, 0, 0, 1, 14'h155, 0);
    chk("after_notify_pld_ready", 32'(bus.pld_ready), 1);
    chk("after_notify_valid_out", 32'(bus.valid_out), 0);
    cyc(0, 0, 0, 1, 14'h155, 0);
    chk("extra_flit_valid", 32'(bus.valid_out), 1);
    chk("extra_flit_data", 32'(bus.data_out), 32'h0554);
    chk("extra_flit_pld_ready", 32'(bus.pld_ready), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("extra_flit_single", 32'(bus.valid_out), 0);
    // reset in the middle of a 4-body packet
    do_reset();
    cyc(1, 1, 4, 0, 0, 0);
    cyc(0, 0, 0, 1, 14'h001, 0);
    cyc(0, 0, 0, 1, 14'h002, 0);
    @(negedge clk);
    bus.pld_valid = 0;
    chk("mid_pkt_valid_before", 32'(bus.valid_out), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid_out", 32'(bus.valid_out), 0);
    chk("mid_rst_credits", 32'(dut.u_cred.credits_q), 3);
    chk("mid_rst_state", 32'(dut.state_q == NI_INJ_IDLE), 1);
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 2, 0, 0, 0, 0);
    chk("post_rst_pkt_ready", 32'(bus.pkt_ready), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("post_rst_valid", 32'(bus.valid_out), 1);
    chk("post_rst_head", 32'(bus.data_out), 32'h0023);
    // send and credit return in the same cycle with one credit left
    do_reset();
    cyc(1, 0, 15, 0, 0, 0);
    cyc(0, 0, 0, 1, 14'h0AA, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 1, 14'(i), 1);
      chk($sformatf("sim%0d_pld_ready", i), 32'(bus.pld_ready), 1);
      chk($sformatf("sim%0d_credits", i), 32'(dut.u_cred.credits_q), 1);
      if (i > 0) cnt += int'(bus.valid_out);
    end
    cyc(0, 0, 0, 0, 0, 0);
    cnt += int'(bus.valid_out);
    chk("sim_flit_count", 32'(cnt), 10);
    chk("sim_end_credits", 32'(dut.u_cred.credits_q), 1);
    // spurious credit return at full count saturates
    do_reset();
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("spurious_credits", 32'(dut.u_cred.credits_q), 3);
    chk("spurious_valid_out", 32'(bus.valid_out), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
